priority_encoder_seq: RTL and testbench

//  Sequential 8-to-3 priority encoder, the return path of the 3-to-8 active-low decoder.

---
 rtl/priority_enc_pkg.sv | 30 +++
 rtl/prio_find.sv | 22 ++
 rtl/priority_encoder_seq.sv | 103 ++++++++++
 tb/tb_priority_encoder_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/priority_enc_pkg.sv
// Shared definitions for the sequential 8-to-3 priority encoder.
//   N_LINES / CODE_W : line count and encoded code width
//   state_t          : two-state handshake FSM encoding
//   line_bit()       : code k <-> request_n bit index (7-k), the decoder's output format
//   req_to_pending() : active-low request bus -> active-high vector indexed by code
package priority_enc_pkg;

  localparam int N_LINES = 8;
  localparam int CODE_W  = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Code k is signalled on request_n[7-k]; the mapping is its own inverse.
  function automatic logic [CODE_W-1:0] line_bit(input logic [CODE_W-1:0] k);
    return CODE_W'(N_LINES - 1) - k;
  endfunction

  function automatic logic [N_LINES-1:0] req_to_pending(input logic [N_LINES-1:0] req_n);
    logic [N_LINES-1:0] vec;
    vec = '0;
    for (int k = 0; k < N_LINES; k++) begin
      vec[k] = ~req_n[line_bit(CODE_W'(k))];
    end
    return vec;
  endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational highest-set-index finder.
//   vec   : input bit vector, bit k = code k
//   idx   : index of the highest set bit (0 when nothing is set)
//   found : at least one bit of vec is set
module prio_find
  import priority_enc_pkg::*;
(
  input  logic [N_LINES-1:0] vec,
  output logic [CODE_W-1:0]  idx,
  output logic               found
);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_LINES; i++) begin
      if (vec[i]) idx = CODE_W'(i);
    end
    found = |vec;
  end

endmodule

// File: rtl/priority_encoder_seq.sv
// Sequential 8-to-3 priority encoder (return path of the 3-to-8 active-low decoder).
//   clk, rst      : clock, asynchronous active-high reset
//   G             : 1 = freeze (no capture, no grant; a presented code is withdrawn)
//   request_n     : active-low requests, code k on request_n[7-k]
//   ack           : consumer accepts the presented code
//   {C,B,A}       : registered code of the current/last grant
//   out_valid     : {C,B,A} carries a pending code awaiting ack
//   any_pend      : at least one pending bit set
//   state_dbg     : current FSM state
//
// Handshake: a code is offered while out_valid=1 and is held stable until the
// cycle where ack=1 and G=0 are sampled at a rising edge; that edge consumes it
// (pending bit cleared, out_valid drops). ack sampled with out_valid=0 is ignored.
module priority_encoder_seq
  import priority_enc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               G,
  input  logic [N_LINES-1:0] request_n,
  input  logic               ack,
  output logic               A,
  output logic               B,
  output logic               C,
  output logic               out_valid,
  output logic               any_pend,
  output state_t             state_dbg
);

  state_t              state_q, state_d;
  logic [N_LINES-1:0]  pending_q, pending_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                out_valid_q, out_valid_d;
  logic                any_pend_q, any_pend_d;

  logic [N_LINES-1:0]  set_vec;
  logic [N_LINES-1:0]  clr_vec;
  logic [CODE_W-1:0]   find_idx;
  logic                find_found;

  // Grants are chosen from the registered pending value, so a request
  // captured at edge n can be granted at edge n+1 at the earliest.
  prio_find u_find (
    .vec   (pending_q),
    .idx   (find_idx),
    .found (find_found)
  );

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    clr_vec  = '0;
    set_vec  = G ? '0 : req_to_pending(request_n);

    case (state_q)
      IDLE: begin
        if (!G && find_found) begin
          code_d  = find_idx;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        // Higher requests arriving here only accumulate in pending; no preemption.
        if (G) begin
          state_d = IDLE;
        end else if (ack) begin
          clr_vec = N_LINES'(1) << code_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Set wins over clear when the acked line is still requesting.
    pending_d   = (pending_q & ~clr_vec) | set_vec;
    out_valid_d = (state_d == PRESENT);
    any_pend_d  = |pending_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      code_q      <= '0;
      out_valid_q <= 1'b0;
      any_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      code_q      <= code_d;
      out_valid_q <= out_valid_d;
      any_pend_q  <= any_pend_d;
    end
  end

  assign A         = code_q[0];
  assign B         = code_q[1];
  assign C         = code_q[2];
  assign out_valid = out_valid_q;
  assign any_pend  = any_pend_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Bench for priority_encoder_seq: directed scenarios followed by random traffic,
// every cycle checked against a behavioural model of pending requests and grants.
module tb_priority_encoder_seq;
  import priority_enc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       G;
  logic [7:0] request_n;
  logic       ack;
  logic       A, B, C;
  logic       out_valid;
  logic       any_pend;
  state_t     state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: set of pending codes, whether a code is being offered, and which.
  bit m_pend[8];
  bit m_valid;
  int m_code;

  always #5 clk = ~clk;

  priority_encoder_seq dut (
    .clk       (clk),
    .rst       (rst),
    .G         (G),
    .request_n (request_n),
    .ack       (ack),
    .A         (A),
    .B         (B),
    .C         (C),
    .out_valid (out_valid),
    .any_pend  (any_pend),
    .state_dbg (state_dbg)
  );

  function automatic bit model_any();
    for (int k = 0; k < 8; k++) if (m_pend[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_highest();
    for (int k = 7; k >= 0; k--) if (m_pend[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_pend[k] = 1'b0;
    m_valid = 1'b0;
    m_code  = 0;
  endtask

  // One rising edge worth of model behaviour, using the inputs currently driven.
  task automatic model_edge();
    bit old_pend[8];
    int hi;
    for (int k = 0; k < 8; k++) old_pend[k] = m_pend[k];
    if (m_valid) begin
      if (G) m_valid = 1'b0;
      else if (ack) begin
        m_pend[m_code] = 1'b0;
        m_valid = 1'b0;
      end
    end else if (!G) begin
      for (int k = 0; k < 8; k++) m_pend[k] = old_pend[k];
      hi = -1;
      for (int k = 7; k >= 0; k--) if (old_pend[k] && hi < 0) hi = k;
      if (hi >= 0) begin
        m_code  = hi;
        m_valid = 1'b1;
      end
    end
    // Requests (code k low on request_n[7-k]) are applied last so they beat a clear.
    if (!G) for (int k = 0; k < 8; k++) if (request_n[7-k] == 1'b0) m_pend[k] = 1'b1;
  endtask

  task automatic check_model(input string tag);
    logic [2:0] cba;
    cba = {C, B, A};
    n_cmp++;
    assert (out_valid === m_valid) else begin
      n_err++;
      $error("FAIL %s out_valid: got %b want %b", tag, out_valid, m_valid);
    end
    n_cmp++;
    assert (any_pend === model_any()) else begin
      n_err++;
      $error("FAIL %s any_pend: got %b want %b", tag, any_pend, model_any());
    end
    n_cmp++;
    assert (cba === 3'(m_code)) else begin
      n_err++;
      $error("FAIL %s code: got %b want %b", tag, cba, 3'(m_code));
    end
  endtask

  // Fixed expectations written straight from the scenario descriptions.
  task automatic expect_out(input string tag, input bit v, input logic [2:0] code, input bit anyp);
    logic [2:0] cba;
    cba = {C, B, A};
    n_cmp++;
    assert (out_valid === v && any_pend === anyp && (!v || cba === code)) else begin
      n_err++;
      $error("FAIL %s: got valid=%b any=%b code=%b want valid=%b any=%b code=%b",
             tag, out_valid, any_pend, cba, v, anyp, code);
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    G = 1'b0; ack = 1'b0; request_n = 8'hFF;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #2;
    check_model("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; G = 1'b0; ack = 1'b0; request_n = 8'hFF;
    model_reset();

    // 1. Reset with all requests asserted, then fill on release.
    @(negedge clk);
    rst = 1'b1; request_n = 8'h00;
    #2;
    expect_out("t1_rst", 1'b0, 3'b000, 1'b0);
    n_cmp++;
    assert ({C, B, A} === 3'b000) else begin
      n_err++;
      $error("FAIL t1_rst_code: got %b want 000", {C, B, A});
    end
    @(posedge clk); #1;
    check_model("t1_held");
    @(negedge clk);
    rst = 1'b0;
    step("t1_fill");
    expect_out("t1_fill_x", 1'b0, 3'b000, 1'b1);
    request_n = 8'hFF;
    step("t1_grant");
    expect_out("t1_grant_x", 1'b1, 3'b111, 1'b1);

    // 2. Single request k=3.
    do_reset();
    request_n = 8'b1110_1111;
    step("t2_cap");
    expect_out("t2_cap_x", 1'b0, 3'b000, 1'b1);
    request_n = 8'hFF;
    step("t2_grant");
    expect_out("t2_grant_x", 1'b1, 3'b011, 1'b1);
    ack = 1'b1;
    step("t2_ack");
    expect_out("t2_ack_x", 1'b0, 3'b011, 1'b0);
    ack = 1'b0;

    // 3. Priority: k=1 and k=6 together.
    do_reset();
    request_n = 8'b1011_1101;
    step("t3_cap");
    request_n = 8'hFF;
    step("t3_g6");
    expect_out("t3_g6_x", 1'b1, 3'b110, 1'b1);
    ack = 1'b1;
    step("t3_ack6");
    expect_out("t3_ack6_x", 1'b0, 3'b110, 1'b1);
    ack = 1'b0;
    step("t3_g1");
    expect_out("t3_g1_x", 1'b1, 3'b001, 1'b1);
    ack = 1'b1;
    step("t3_ack1");
    expect_out("t3_ack1_x", 1'b0, 3'b001, 1'b0);
    ack = 1'b0;

    // 4. No preempt by k=7, set-wins for held k=2.
    do_reset();
    request_n = 8'b1101_1111;
    step("t4_cap");
    step("t4_g2");
    expect_out("t4_g2_x", 1'b1, 3'b010, 1'b1);
    request_n = 8'b1101_1110;
    step("t4_nopre");
    expect_out("t4_nopre_x", 1'b1, 3'b010, 1'b1);
    request_n = 8'b1101_1111; ack = 1'b1;
    step("t4_ack2");
    ack = 1'b0; request_n = 8'hFF;
    step("t4_g7");
    expect_out("t4_g7_x", 1'b1, 3'b111, 1'b1);
    ack = 1'b1;
    step("t4_ack7");
    ack = 1'b0;
    step("t4_g2b");
    expect_out("t4_g2b_x", 1'b1, 3'b010, 1'b1);
    ack = 1'b1;
    step("t4_ack2b");
    expect_out("t4_ack2b_x", 1'b0, 3'b010, 1'b0);
    ack = 1'b0;

    // 5. Disable during PRESENT; requests under G=1 are dropped.
    do_reset();
    request_n = 8'b1111_1011;
    step("t5_cap");
    request_n = 8'hFF;
    step("t5_g5");
    G = 1'b1; request_n = 8'b1111_1110;
    step("t5_freeze");
    expect_out("t5_freeze_x", 1'b0, 3'b101, 1'b1);
    request_n = 8'hFF;
    step("t5_frz2");
    G = 1'b0;
    step("t5_regrant");
    expect_out("t5_regrant_x", 1'b1, 3'b101, 1'b1);
    ack = 1'b1;
    step("t5_ack");
    expect_out("t5_ack_x", 1'b0, 3'b101, 1'b0);
    ack = 1'b0;

    // 6. Async reset mid-PRESENT, then a stray ack.
    do_reset();
    request_n = 8'b1111_0111;
    step("t6_cap");
    request_n = 8'hFF;
    step("t6_g4");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    expect_out("t6_async_x", 1'b0, 3'b000, 1'b0);
    check_model("t6_async");
    @(negedge clk);
    rst = 1'b0;
    ack = 1'b1;
    step("t6_stray_ack");
    expect_out("t6_stray_x", 1'b0, 3'b000, 1'b0);
    ack = 1'b0;

    // Random traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       request_n = 8'hFF;
        1:       request_n = ~(8'd1 << $urandom_range(0, 7));
        2:       request_n = 8'($urandom) | 8'($urandom);
        default: request_n = 8'hFF;
      endcase
      G   = ($urandom_range(0, 9) == 0);
      ack = ($urandom_range(0, 1) == 1);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
